// File: rtl/typing_pkg.sv
// Shared constants and encodings for the typing-game text window.
package typing_pkg;

  localparam int unsigned WIN_DEFAULT = 30;
  localparam int unsigned CELL_W      = 5;
  localparam int unsigned CHAR_SPACE  = 26;

  typedef enum logic [1:0] {
    ST_PEND = 2'd0,
    ST_OK   = 2'd1,
    ST_BAD  = 2'd2,
    ST_CUR  = 2'd3
  } stat_e;

  // IDLE only exists for the single cycle after reset release.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/text_window_buffer_if.sv
// Checker, article-lookup and renderer signals of the text window buffer.
interface text_window_buffer_if #(
  parameter int unsigned PLACE_W = 11,
  parameter int unsigned CHAR_W  = 6
);
  logic               restart;
  logic [PLACE_W-1:0] word_place;
  logic               judge_valid;
  logic               judge_wrong;
  logic [PLACE_W-1:0] art_addr;
  logic [CHAR_W-1:0]  art_char;
  logic [4:0]         cell_idx;
  logic [CHAR_W-1:0]  cell_char;
  logic [1:0]         cell_stat;
  logic [PLACE_W-1:0] line_base;
  logic               busy;
  logic               done;
  logic               overflow;

  modport slave (
    input  restart, word_place, judge_valid, judge_wrong, art_char, cell_idx,
    output art_addr, cell_char, cell_stat, line_base, busy, done, overflow
  );

  modport master (
    output restart, word_place, judge_valid, judge_wrong, art_char, cell_idx,
    input  art_addr, cell_char, cell_stat, line_base, busy, done, overflow
  );
endinterface

// File: rtl/cell_status_array.sv
// Per-cell judgement status storage: one write port, one registered read port.
module cell_status_array
  import typing_pkg::*;
#(
  parameter int unsigned WIN = WIN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [CELL_W-1:0] waddr,
  input  stat_e             wdata,
  input  logic [CELL_W-1:0] raddr,
  output stat_e             rdata
);

  stat_e stat_q [WIN];
  stat_e rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(WIN); i++) begin
        stat_q[i] <= ST_PEND;
      end
      rdata_q <= ST_PEND;
    end else begin
      if (we) begin
        stat_q[waddr] <= wdata;
      end
      rdata_q <= stat_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/text_window_buffer.sv
// One displayed line of article text plus per-cell judgement status,
// refilled a line at a time from the article lookup as the cursor moves.
module text_window_buffer
  import typing_pkg::*;
#(
  parameter int unsigned WIN     = WIN_DEFAULT,
  parameter int unsigned ART_LEN = 299,
  parameter int unsigned PLACE_W = 11,
  parameter int unsigned CHAR_W  = 6
) (
  input logic                clk,
  input logic                rst,
  text_window_buffer_if.slave bus
);

  localparam logic [PLACE_W-1:0] WIN_P   = PLACE_W'(WIN);
  localparam logic [PLACE_W-1:0] ART_P   = PLACE_W'(ART_LEN);
  localparam logic [CELL_W-1:0]  WIN_C   = CELL_W'(WIN);
  localparam logic [CELL_W-1:0]  LAST_C  = CELL_W'(WIN - 1);
  localparam logic [CHAR_W-1:0]  SPACE_C = CHAR_W'(CHAR_SPACE);

  state_e             state_q, state_d;
  logic [PLACE_W-1:0] base_q, base_d;
  logic [CELL_W-1:0]  fill_q, fill_d;
  logic               q_valid_q, q_valid_d;
  logic [PLACE_W-1:0] q_place_q, q_place_d;
  logic               q_wrong_q, q_wrong_d;
  logic               ovf_q, ovf_d;

  logic [CHAR_W-1:0]  chars_q [WIN];
  logic [CHAR_W-1:0]  cell_char_q;
  logic               stat_zero_q;
  logic               stat_cur_q;

  logic               st_we;
  logic [CELL_W-1:0]  st_waddr;
  stat_e              st_wdata;
  stat_e              st_rdata;
  logic               char_we;

  logic [PLACE_W-1:0] fill_addr;
  logic [CHAR_W-1:0]  fill_char;
  logic [PLACE_W-1:0] base_next;
  logic [PLACE_W:0]   cur_off, q_off;
  logic               cur_in, q_in;
  logic [CELL_W-1:0]  cur_idx, q_idx;
  logic               rd_in;
  logic [CELL_W-1:0]  rd_addr;

  assign fill_addr = base_q + {{(PLACE_W - CELL_W){1'b0}}, fill_q};
  assign fill_char = (fill_addr >= ART_P) ? SPACE_C : bus.art_char;
  assign base_next = base_q + WIN_P;

  // Extra MSB flags a place behind the line start, which counts as out of window.
  assign cur_off = {1'b0, bus.word_place} - {1'b0, base_q};
  assign cur_in  = !cur_off[PLACE_W] && (cur_off < {1'b0, WIN_P});
  assign cur_idx = cur_off[CELL_W-1:0];
  assign q_off   = {1'b0, q_place_q} - {1'b0, base_q};
  assign q_in    = !q_off[PLACE_W] && (q_off < {1'b0, WIN_P});
  assign q_idx   = q_off[CELL_W-1:0];

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    fill_d    = fill_q;
    q_valid_d = q_valid_q;
    q_place_d = q_place_q;
    q_wrong_d = q_wrong_q;
    ovf_d     = ovf_q;
    st_we     = 1'b0;
    st_waddr  = cur_idx;
    st_wdata  = ST_PEND;
    char_we   = 1'b0;

    if (bus.restart) begin
      state_d   = FILL;
      base_d    = '0;
      fill_d    = '0;
      q_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, FILL: begin
          if (state_q == FILL) begin
            char_we  = 1'b1;
            st_we    = 1'b1;
            st_waddr = fill_q;
            st_wdata = ST_PEND;
            if (fill_q == LAST_C) begin
              state_d = RUN;
              fill_d  = '0;
            end else begin
              fill_d = fill_q + 1'b1;
            end
          end else begin
            state_d = FILL;
            fill_d  = '0;
          end
          if (bus.judge_valid) begin
            if (q_valid_q) begin
              ovf_d = 1'b1;
            end else begin
              q_valid_d = 1'b1;
              q_place_d = bus.word_place;
              q_wrong_d = bus.judge_wrong;
            end
          end
        end
        RUN: begin
          // A queued judgement owns the write port; a fresh one takes its slot.
          if (q_valid_q) begin
            st_we     = q_in;
            st_waddr  = q_idx;
            st_wdata  = q_wrong_q ? ST_BAD : ST_OK;
            q_valid_d = bus.judge_valid;
            q_place_d = bus.word_place;
            q_wrong_d = bus.judge_wrong;
          end else if (bus.judge_valid && cur_in) begin
            st_we    = 1'b1;
            st_waddr = cur_idx;
            st_wdata = bus.judge_wrong ? ST_BAD : ST_OK;
          end
          if (bus.word_place >= ART_P) begin
            state_d = DONE;
          end else if ((bus.word_place >= base_next) && (base_next < ART_P)) begin
            base_d  = base_next;
            state_d = FILL;
            fill_d  = '0;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      fill_q    <= '0;
      q_valid_q <= 1'b0;
      q_place_q <= '0;
      q_wrong_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      fill_q    <= fill_d;
      q_valid_q <= q_valid_d;
      q_place_q <= q_place_d;
      q_wrong_q <= q_wrong_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (char_we) begin
      chars_q[fill_q] <= fill_char;
    end
  end

  assign rd_in   = bus.cell_idx < WIN_C;
  assign rd_addr = rd_in ? bus.cell_idx : '0;

  // Status is forced to pending from the cycle a fill is triggered until it ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_char_q <= '0;
      stat_zero_q <= 1'b1;
      stat_cur_q  <= 1'b0;
    end else begin
      cell_char_q <= rd_in ? chars_q[rd_addr] : SPACE_C;
      stat_zero_q <= !rd_in || (state_q == IDLE) || (state_q == FILL) || (state_d == FILL);
      stat_cur_q  <= (state_q == RUN) && (state_d == RUN) && cur_in && (cur_idx == bus.cell_idx);
    end
  end

  cell_status_array #(
    .WIN(WIN)
  ) u_status (
    .clk  (clk),
    .rst  (rst),
    .we   (st_we),
    .waddr(st_waddr),
    .wdata(st_wdata),
    .raddr(rd_addr),
    .rdata(st_rdata)
  );

  assign bus.art_addr  = fill_addr;
  assign bus.cell_char = cell_char_q;
  assign bus.cell_stat = stat_zero_q ? ST_PEND :
                         ((stat_cur_q && (st_rdata == ST_PEND)) ? ST_CUR : st_rdata);
  assign bus.line_base = base_q;
  assign bus.busy      = (state_q == FILL);
  assign bus.done      = (state_q == DONE);
  assign bus.overflow  = ovf_q;

endmodule
